// File: rtl/trisc_datapath.sv
// TRISC register-transfer datapath: PC, MAR, MDR, IR, AC and a unified program/data memory.
// The control unit sequences every transfer through the control word C.
module trisc_datapath #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          SysClock,
    input  logic          Reset,
    input  logic [14:0]   C,
    output logic [3:0]    IRout,
    output logic          Zero,
    output logic          Neg,
    output logic [AW-1:0] PCout,
    output logic [DW-1:0] ACout,
    input  logic          ProgWE,
    input  logic [AW-1:0] ProgAddr,
    input  logic [DW-1:0] ProgData
);

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] AC_ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [AW-1:0] pc_reg, pc_next;
    logic [AW-1:0] mar_reg, mar_next;
    logic [DW-1:0] mdr_reg, mdr_next;
    logic [DW-1:0] ir_reg, ir_next;
    logic [DW-1:0] ac_reg, ac_next;
    logic [DW-1:0] mem [2**AW];
    logic          unused_c6;

    assign unused_c6 = C[6];

    // Program load wins over the datapath store; reset blocks only the store.
    always_ff @(posedge SysClock) begin
        if (ProgWE) begin
            mem[ProgAddr] <= ProgData;
        end else if (C[8] && !Reset) begin
            mem[mar_reg] <= mdr_reg;
        end
    end

    always_comb begin
        pc_next = pc_reg;
        if (C[14]) begin
            pc_next = ir_reg[AW-1:0];
        end else if (C[1]) begin
            pc_next = pc_reg + PC_ONE;
        end

        mar_next = mar_reg;
        if (C[4]) begin
            mar_next = ir_reg[AW-1:0];
        end else if (C[0]) begin
            mar_next = pc_reg;
        end

        mdr_next = mdr_reg;
        if (C[2]) begin
            mdr_next = mem[mar_reg];
        end else if (C[7]) begin
            mdr_next = ac_reg;
        end

        ir_next = C[3] ? mdr_reg : ir_reg;

        // Fixed priority keeps illegal multi-hot words deterministic.
        ac_next = ac_reg;
        if (C[13]) begin
            ac_next = '0;
        end else if (C[5]) begin
            ac_next = mdr_reg;
        end else if (C[9]) begin
            ac_next = ac_reg + mdr_reg;
        end else if (C[10]) begin
            ac_next = ac_reg - mdr_reg;
        end else if (C[11]) begin
            ac_next = ac_reg ^ mdr_reg;
        end else if (C[12]) begin
            ac_next = ac_reg + AC_ONE;
        end
    end

    always_ff @(posedge SysClock) begin
        if (Reset) begin
            pc_reg  <= '0;
            mar_reg <= '0;
            mdr_reg <= '0;
            ir_reg  <= '0;
            ac_reg  <= '0;
        end else begin
            pc_reg  <= pc_next;
            mar_reg <= mar_next;
            mdr_reg <= mdr_next;
            ir_reg  <= ir_next;
            ac_reg  <= ac_next;
        end
    end

    assign IRout = ir_reg[DW-1:DW-4];
    assign Zero  = (ac_reg == '0);
    assign Neg   = ac_reg[DW-1];
    assign PCout = pc_reg;
    assign ACout = ac_reg;

endmodule
